dispense_order_dispatcher: RTL and testbench
============================================

// Module: dispense_order_dispatcher
// PURPOSE
//  Upstream stage of the per-slot dispense controllers: accepts snack orders
//  {slot, count} from the command front-end, buffers them in a small FIFO and
//  dispatches them one at a time, pulsing start_dispense to the selected slot
//  and tracking that slot's busy flag until the dispense completes.
//  Dispatching is serial: at most one servo moves at any time, which bounds supply current.
// PARAMETERS
//  NUM_SLOTS    4   number of downstream dispense controllers (2..8)
//  FIFO_DEPTH   4   order queue depth; power of two, 2..16
//  BUSY_TIMEOUT 16  cycles allowed for slot_busy to rise after a start pulse
// PORTS
//  clk             in   1          system clock
//  rst_n           in   1          asynchronous active-low reset
//  order_valid     in   1          order present on order_slot/order_count
//  order_ready     out  1          queue can accept (= !full)
//  order_slot      in   3          target slot index
//  order_count     in   3          items to dispense (1..7)
//  start_dispense  out  NUM_SLOTS  one-hot, one-cycle start pulse
//  dispense_count  out  3          count for active order; stable while issued
//  slot_busy       in   NUM_SLOTS  busy flags from the dispense controllers
//  queue_level     out  5          orders currently held in the FIFO
//  dispatch_active out  1          high from ISSUE through WAIT_DONE
//  order_done      out  1          one-cycle pulse when an order completes
//  order_reject    out  1          one-cycle pulse: bad order dropped or start timed out
// BEHAVIOUR
//  Reset (async, rst_n low): FIFO emptied, state IDLE. start_dispense=0,
//   dispense_count=0, queue_level=0, dispatch_active=0, order_done=0,
//   order_reject=0. order_ready=1 after reset deasserts. Any in-flight order is lost.
//  Accept: push on posedge clk when order_valid && order_ready. When full,
//   order_ready=0 even if a pop happens in the same cycle (no pass-through).
//   Simultaneous push+pop when not full: queue_level unchanged.
//  Queue pointers wrap modulo FIFO_DEPTH; queue_level ranges 0..FIFO_DEPTH.
//  All outputs are registered.
//  FSM states:
//   IDLE: FIFO non-empty -> inspect head. If head slot >= NUM_SLOTS or head
//    count == 0: pop it, pulse order_reject next cycle, stay IDLE. Otherwise,
//    if slot_busy[head slot]==0: pop, latch slot/count -> ISSUE. If that slot
//    is busy: hold the head (no pop) until the slot goes idle.
//   ISSUE (1 cycle): start_dispense[slot]=1, dispense_count=latched count,
//    dispatch_active=1 -> WAIT_BUSY.
//   WAIT_BUSY: timer counts. slot_busy[slot]==1 -> WAIT_DONE. Timer reaches
//    BUSY_TIMEOUT without busy -> pulse order_reject -> IDLE (order dropped, no retry).
//   WAIT_DONE: slot_busy[slot] falls to 0 -> pulse order_done -> IDLE.
//    No timeout (dispense of 7 items is legitimately ~10 s).
//  dispense_count holds its value from ISSUE until the next ISSUE; 0 after reset.
//  Latency: order accepted at edge T into an empty queue with the slot idle ->
//   start_dispense high in cycle T+2.
//  Minimum back-to-back spacing: after order_done, the next start_dispense pulse
//   follows no sooner than 2 cycles later.
//  slot_busy bits for non-selected slots are ignored, except in the IDLE hold check.
// TESTING
//  1 reset, push {slot 2, count 3}, model busy high 1 cycle after start, low after 100
//    -> start_dispense=4'b0100 at T+2, dispense_count=3, one order_done pulse.
//  2 push 5 orders back-to-back, order_valid held high, no dispatch progress
//    -> 4 accepted, order_ready=0 after 4th push, queue_level=4; one pop -> ready=1.
//  3 push {slot 5, count 2} then {slot 1, count 0}
//    -> two order_reject pulses, no start_dispense, queue_level returns to 0.
//  4 push {slot 0, count 1}, slot_busy held low
//    -> order_reject exactly 16 cycles after WAIT_BUSY entry, FSM back to IDLE.
//  5 slot_busy[1]=1 externally, push {slot 1, count 2}
//    -> no start pulse while busy; start_dispense[1] 2 cycles after busy clears.
//  6 assert rst_n=0 during WAIT_DONE with 2 orders queued
//    -> all outputs 0 immediately, queue_level=0, no order_done afterwards.

Source files
------------

// File: rtl/dispense_order_dispatcher.sv
// Dispense order dispatcher: queues {slot, count} orders and issues them one
// at a time to the per-slot dispense controllers, so at most one servo runs.
module dispense_order_dispatcher #(
  parameter int NUM_SLOTS    = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 order_valid,
  output logic                 order_ready,
  input  logic [2:0]           order_slot,
  input  logic [2:0]           order_count,
  output logic [NUM_SLOTS-1:0] start_dispense,
  output logic [2:0]           dispense_count,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  output logic [4:0]           queue_level,
  output logic                 dispatch_active,
  output logic                 order_done,
  output logic                 order_reject
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [4:0]       DEPTH_L  = 5'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  // Pick one slot's flag out of a slot vector; out-of-range index reads 0.
  function automatic logic slot_bit(input logic [NUM_SLOTS-1:0] vec, input logic [2:0] idx);
    logic bit_s;
    bit_s = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idx == 3'(i)) bit_s = vec[i];
    end
    return bit_s;
  endfunction

  // One-hot select for a slot index; out-of-range index yields all zeros.
  function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [2:0] idx);
    logic [NUM_SLOTS-1:0] oh_s;
    oh_s = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idx == 3'(i)) oh_s[i] = 1'b1;
    end
    return oh_s;
  endfunction

  state_t               state_r, state_s;
  logic [2:0]           fifo_slot_r [FIFO_DEPTH];
  logic [2:0]           fifo_cnt_r  [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [4:0]           level_r, level_s;
  logic                 ready_r, ready_s;
  logic [2:0]           cur_slot_r, cur_count_r;
  logic [TMR_W-1:0]     timer_r, timer_s;
  logic [NUM_SLOTS-1:0] start_r, start_s;
  logic [2:0]           dcount_r, dcount_s;
  logic                 active_r, active_s;
  logic                 done_r, done_s;
  logic                 reject_r, reject_s;
  logic                 push_s, pop_s, latch_s;
  logic [2:0]           head_slot_s, head_cnt_s;
  logic                 head_bad_s, head_busy_s, cur_busy_s;

  assign push_s      = order_valid && ready_r;
  assign head_slot_s = fifo_slot_r[rd_ptr_r];
  assign head_cnt_s  = fifo_cnt_r[rd_ptr_r];
  // Widen the slot index so NUM_SLOTS = 8 still compares correctly.
  assign head_bad_s  = ({1'b0, head_slot_s} >= 4'(NUM_SLOTS)) || (head_cnt_s == 3'd0);
  assign head_busy_s = slot_bit(slot_busy, head_slot_s);
  assign cur_busy_s  = slot_bit(slot_busy, cur_slot_r);

  assign order_ready     = ready_r;
  assign queue_level     = level_r;
  assign start_dispense  = start_r;
  assign dispense_count  = dcount_r;
  assign dispatch_active = active_r;
  assign order_done      = done_r;
  assign order_reject    = reject_r;

  // Dispatch FSM: head inspection, issue, wait for busy to rise, wait for busy to fall.
  always_comb begin
    state_s  = state_r;
    timer_s  = timer_r;
    pop_s    = 1'b0;
    latch_s  = 1'b0;
    reject_s = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (level_r != 5'd0) begin
          if (head_bad_s) begin
            pop_s    = 1'b1;
            reject_s = 1'b1;
          end else if (!head_busy_s) begin
            pop_s   = 1'b1;
            latch_s = 1'b1;
            state_s = ST_ISSUE;
          end else begin
            // Target slot still busy: keep the order at the head.
            pop_s = 1'b0;
          end
        end else begin
          pop_s = 1'b0;
        end
      end
      ST_ISSUE: begin
        timer_s = '0;
        state_s = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (cur_busy_s) begin
          state_s = ST_WAIT_DONE;
        end else if (timer_r == TMO_LAST) begin
          // Controller never acknowledged the start: drop the order, no retry.
          reject_s = 1'b1;
          state_s  = ST_IDLE;
        end else begin
          timer_s = timer_r + TMR_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!cur_busy_s) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Next values for queue occupancy and the registered outputs.
  always_comb begin
    level_s  = level_r;
    start_s  = '0;
    dcount_s = dcount_r;
    case ({push_s, pop_s})
      2'b10:   level_s = level_r + 5'd1;
      2'b01:   level_s = level_r - 5'd1;
      default: level_s = level_r;
    endcase
    // Ready comes from the post-update level, so a full queue never passes through.
    ready_s  = (level_s != DEPTH_L);
    active_s = (state_s != ST_IDLE);
    if (state_r == ST_ISSUE) begin
      start_s  = slot_onehot(cur_slot_r);
      dcount_s = cur_count_r;
    end else begin
      start_s  = '0;
      dcount_s = dcount_r;
    end
  end

  // Order storage: write the accepted order at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_slot_r[i] <= 3'd0;
        fifo_cnt_r[i]  <= 3'd0;
      end
    end else if (push_s) begin
      fifo_slot_r[wr_ptr_r] <= order_slot;
      fifo_cnt_r[wr_ptr_r]  <= order_count;
    end
  end

  // Queue pointers (wrap naturally at FIFO_DEPTH) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= 5'd0;
      ready_r  <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      level_r <= level_s;
      ready_r <= ready_s;
    end
  end

  // FSM state, start timer and the latched active order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      timer_r     <= '0;
      cur_slot_r  <= 3'd0;
      cur_count_r <= 3'd0;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      if (latch_s) begin
        cur_slot_r  <= head_slot_s;
        cur_count_r <= head_cnt_s;
      end
    end
  end

  // Registered outputs toward the controllers and the front-end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r  <= '0;
      dcount_r <= 3'd0;
      active_r <= 1'b0;
      done_r   <= 1'b0;
      reject_r <= 1'b0;
    end else begin
      start_r  <= start_s;
      dcount_r <= dcount_s;
      active_r <= active_s;
      done_r   <= done_s;
      reject_r <= reject_s;
    end
  end

endmodule

// File: tb/tb_dispense_order_dispatcher.sv
// Bench for dispense_order_dispatcher: directed scenarios plus a randomized
// run scored against an order-queue reference and a downstream slot model.
module tb_dispense_order_dispatcher;

  localparam int NS    = 4;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  typedef struct packed {
    logic [2:0] slot;
    logic [2:0] cnt;
  } ord_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          order_valid = 1'b0;
  logic [2:0]    order_slot = 3'd0;
  logic [2:0]    order_count = 3'd0;
  logic [NS-1:0] slot_busy = '0;
  logic          order_ready;
  logic [NS-1:0] start_dispense;
  logic [2:0]    dispense_count;
  logic [4:0]    queue_level;
  logic          dispatch_active;
  logic          order_done;
  logic          order_reject;

  always #5 clk = ~clk;

  dispense_order_dispatcher #(.NUM_SLOTS(NS), .FIFO_DEPTH(DEPTH), .BUSY_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .order_valid(order_valid), .order_ready(order_ready),
    .order_slot(order_slot), .order_count(order_count), .start_dispense(start_dispense),
    .dispense_count(dispense_count), .slot_busy(slot_busy), .queue_level(queue_level),
    .dispatch_active(dispatch_active), .order_done(order_done), .order_reject(order_reject)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0;
  int n_start = 0, n_done = 0, n_rej = 0, n_acc = 0;
  bit auto_busy = 1'b0, mon_en = 1'b0, rnd_busy = 1'b0;
  int fix_dly = 1, fix_len = 1;
  int dly [NS];
  int len [NS];
  int len_cfg [NS];
  ord_t exp_q [$];
  int pend = 0;               // 0 none, 1 expect done, 2 expect timeout reject
  int start_cyc = 0, fall_cyc = 0, done_cyc = -100;
  logic [2:0] cur_cnt = 3'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic is_bad(input ord_t o);
    return (o.slot >= 3'(NS)) || (o.cnt == 3'd0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      dly[i] = 0;
      len[i] = 0;
      len_cfg[i] = 1;
    end
    pend = 0;
    exp_q.delete();
    if (auto_busy) slot_busy = '0;
  endtask

  // Reference: accepted orders leave the queue in order; each produces a
  // reject (bad order or start timeout) or a start followed by a done.
  task automatic scoreboard(input logic acc, input ord_t o_in);
    ord_t o;
    logic [NS-1:0] exp_start;
    if (acc) exp_q.push_back(o_in);
    if (order_reject) begin
      if (pend == 2) begin
        check("tmo_latency", cyc - start_cyc, TMO);
        pend = 0;
      end else if (pend == 1) begin
        check("reject_during_dispense", order_reject, 0);
      end else if (exp_q.size() == 0) begin
        check("reject_unexpected", order_reject, 0);
      end else begin
        o = exp_q.pop_front();
        check("reject_bad_order", is_bad(o), 1);
      end
    end
    if (start_dispense != '0) begin
      if (pend != 0 || exp_q.size() == 0) begin
        check("start_unexpected", start_dispense, 0);
      end else begin
        o = exp_q.pop_front();
        exp_start = is_bad(o) ? '0 : (NS'(1) << o.slot);
        check("start_onehot", start_dispense, exp_start);
        check("start_count", dispense_count, o.cnt);
        check("start_spacing", (cyc - done_cyc) >= 2, 1);
        cur_cnt   = o.cnt;
        start_cyc = cyc;
      end
    end
    if (order_done) begin
      check("done_expected", pend, 1);
      check("done_latency", cyc - fall_cyc, 1);
      check("done_count_stable", dispense_count, cur_cnt);
      pend = 0;
      done_cyc = cyc;
    end
  endtask

  // Downstream slot controllers: busy rises some cycles after a start
  // pulse (or never), then stays high for a chosen duration.
  task automatic downstream();
    int d, l;
    for (int i = 0; i < NS; i++) begin
      if (len[i] > 0) begin
        len[i]--;
        if (len[i] == 0) begin
          slot_busy[i] = 1'b0;
          fall_cyc = cyc;
        end
      end else if (dly[i] > 0) begin
        dly[i]--;
        if (dly[i] == 0) begin
          slot_busy[i] = 1'b1;
          len[i] = len_cfg[i];
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (start_dispense[i]) begin
        if (rnd_busy) begin
          d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 10));
          l = int'($urandom_range(1, 20));
        end else begin
          d = fix_dly;
          l = fix_len;
        end
        if (d > 0) dly[i] = d;
        len_cfg[i] = l;
        if (mon_en) pend = (d > 0) ? 1 : 2;
      end
    end
  endtask

  task automatic tick();
    logic acc;
    ord_t o_in;
    acc = order_valid && order_ready && rst_n;
    o_in.slot = order_slot;
    o_in.cnt  = order_count;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) n_acc++;
    if (start_dispense != '0) n_start++;
    if (order_done) n_done++;
    if (order_reject) n_rej++;
    if (mon_en) scoreboard(acc, o_in);
    if (auto_busy) downstream();
  endtask

  task automatic drive(input logic [2:0] s, input logic [2:0] c);
    order_valid = 1'b1;
    order_slot  = s;
    order_count = c;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int s0, d0, r0, a0;
    logic r4;
    bit drained;
    model_reset();

    // Reset state.
    #3;
    check("rst_start", start_dispense, 0);
    check("rst_count", dispense_count, 0);
    check("rst_level", queue_level, 0);
    check("rst_active", dispatch_active, 0);
    check("rst_done", order_done, 0);
    check("rst_reject", order_reject, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check("rst_ready", order_ready, 1);

    // 1: single order, latency and one done pulse.
    auto_busy = 1'b1; fix_dly = 1; fix_len = 100; model_reset();
    s0 = n_start; d0 = n_done;
    drive(3'd2, 3'd3);
    tick();
    order_valid = 1'b0;
    check("t1_level_push", queue_level, 1);
    tick();
    check("t1_start_early", start_dispense, 0);
    check("t1_active", dispatch_active, 1);
    tick();
    check("t1_start", start_dispense, 4'b0100);
    check("t1_count", dispense_count, 3);
    for (int k = 0; k < 200 && n_done == d0; k++) tick();
    repeat (5) tick();
    check("t1_done_pulses", n_done - d0, 1);
    check("t1_starts", n_start - s0, 1);
    check("t1_count_hold", dispense_count, 3);
    check("t1_idle", dispatch_active, 0);

    // 2: fill the queue behind a busy slot.
    auto_busy = 1'b0; slot_busy = 4'b0001;
    a0 = n_acc; s0 = n_start; d0 = n_done; r4 = 1'b1;
    drive(3'd0, 3'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 3) r4 = order_ready;
    end
    check("t2_accepted", n_acc - a0, 4);
    check("t2_ready_after4", r4, 0);
    check("t2_ready_full", order_ready, 0);
    check("t2_level", queue_level, 4);
    check("t2_no_start", n_start - s0, 0);
    order_valid = 1'b0;
    auto_busy = 1'b1; fix_dly = 1; fix_len = 3; model_reset();
    tick();
    check("t2_level_pop", queue_level, 3);
    check("t2_ready_pop", order_ready, 1);
    for (int k = 0; k < 300 && (queue_level != 5'd0 || dispatch_active); k++) tick();
    check("t2_drained", queue_level, 0);
    check("t2_starts", n_start - s0, 4);
    check("t2_dones", n_done - d0, 4);

    // 3: bad slot and zero count are dropped.
    s0 = n_start; r0 = n_rej;
    drive(3'd5, 3'd2);
    tick();
    drive(3'd1, 3'd0);
    tick();
    order_valid = 1'b0;
    check("t3_rej_first", order_reject, 1);
    tick();
    check("t3_rej_second", order_reject, 1);
    tick();
    check("t3_rej_end", order_reject, 0);
    repeat (3) tick();
    check("t3_rejects", n_rej - r0, 2);
    check("t3_no_start", n_start - s0, 0);
    check("t3_level", queue_level, 0);

    // 4: start never acknowledged -> timeout reject.
    fix_dly = -1; model_reset();
    drive(3'd0, 3'd1);
    tick();
    order_valid = 1'b0;
    tick();
    tick();
    check("t4_start", start_dispense, 4'b0001);
    r0 = n_rej;
    for (int k = 1; k < TMO; k++) tick();
    check("t4_no_early_reject", n_rej - r0, 0);
    check("t4_active_wait", dispatch_active, 1);
    tick();
    check("t4_reject_at_timeout", order_reject, 1);
    check("t4_active_off", dispatch_active, 0);
    tick();
    check("t4_reject_pulse", order_reject, 0);
    check("t4_no_retry", start_dispense, 0);

    // 5: head held while its slot is busy.
    auto_busy = 1'b0; slot_busy = 4'b0010; s0 = n_start;
    drive(3'd1, 3'd2);
    tick();
    order_valid = 1'b0;
    repeat (10) tick();
    check("t5_held_no_start", n_start - s0, 0);
    check("t5_held_level", queue_level, 1);
    slot_busy = 4'b0000;
    tick();
    check("t5_start_early", start_dispense, 0);
    tick();
    check("t5_start", start_dispense, 4'b0010);
    check("t5_count", dispense_count, 2);
    slot_busy = 4'b0010;
    repeat (3) tick();
    slot_busy = 4'b0000; d0 = n_done;
    repeat (3) tick();
    check("t5_done", n_done - d0, 1);

    // 6: reset in WAIT_DONE with two orders queued.
    auto_busy = 1'b1; fix_dly = 1; fix_len = 1000; model_reset();
    drive(3'd3, 3'd7);
    repeat (3) tick();
    order_valid = 1'b0;
    repeat (5) tick();
    check("t6_level_before", queue_level, 2);
    check("t6_active_before", dispatch_active, 1);
    d0 = n_done; s0 = n_start;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_start", start_dispense, 0);
    check("t6_rst_count", dispense_count, 0);
    check("t6_rst_level", queue_level, 0);
    check("t6_rst_active", dispatch_active, 0);
    check("t6_rst_done", order_done, 0);
    check("t6_rst_reject", order_reject, 0);
    check("t6_rst_ready", order_ready, 0);
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) tick();
    check("t6_no_done", n_done - d0, 0);
    check("t6_no_start", n_start - s0, 0);
    check("t6_level_after", queue_level, 0);
    check("t6_ready_after", order_ready, 1);

    // Randomized traffic against the reference queue.
    rnd_busy = 1'b1; model_reset(); mon_en = 1'b1; done_cyc = cyc - 10;
    for (int k = 0; k < 1500; k++) begin
      order_valid = ($urandom_range(0, 2) == 0);
      order_slot  = 3'($urandom_range(0, 5));
      order_count = 3'($urandom_range(0, 7));
      tick();
    end
    order_valid = 1'b0;
    drained = 1'b0;
    for (int k = 0; k < 3000 && !drained; k++) begin
      tick();
      if (exp_q.size() == 0 && pend == 0 && queue_level == 5'd0 && !dispatch_active) drained = 1'b1;
    end
    check("rand_drained", drained, 1);
    check("rand_level", queue_level, 0);
    check("rand_pending_orders", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
